sram_sraml_bridge: RTL and testbench
====================================

# sram_sraml_bridge

Parametrised bridge that turns a single-cycle SRAM-style request from the pipeline (enable, address, byte write-enables, write data) into a one-outstanding SRAM-like handshake (req/addr_ok/data_ok). It serves as the common bridge for both the instruction side (read-only mode) and the data side, and sits between the core datapath and the cache/AXI interface. It generates the stall for its own pipeline stage and holds returned read data until every stall source in the core has cleared. It adds what the per-side bridges lacked:
- automatic size/address-offset encoding from write-enables;
- illegal byte-enable detection;
- request latching;
- configurable address width and read-only mode.

## Interface
Parameters:
- ADDR_W, 32, address width of both sides.
- READ_ONLY, 0, 1 forces `wr`=0 and `wdata`=0; `sram_wen` is ignored (instruction side).

Ports (`clk`, `rst`: one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- sram_en  in  1  access request from pipeline stage.
- sram_addr  in  ADDR_W  byte address.
- sram_wen  in  4  byte write-enables; 0000 means read.
- sram_wdata  in  32  write data, lane-aligned.
- sram_rdata  out  32  read data, valid while state DONE.
- stall  out  1  this bridge needs the pipeline frozen.
- longest_stall  in  1  OR of all core stall sources.
- err  out  1  one-cycle pulse: illegal wen pattern, no request issued.
- req  out  1  SRAM-like request.
- wr  out  1  1 = write.
- size  out  2  0 byte, 1 half, 2 word.
- addr  out  ADDR_W  request address.
- wdata  out  32  request write data.
- addr_ok  in  1  address accepted.
- data_ok  in  1  data returned / write done.
- rdata  in  32  read return data.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - `sram_en`=1 with a legal wen latches addr/wen/wdata.
  - Latched size and addr[1:0]:
    - 0000 → size 2, addr[1:0]=00, wr=0.
    - 1111 → size 2, addr[1:0]=00, wr=1.
    - 0011 → size 1, offset 00. 1100 → size 1, offset 10.
    - 0001/0010/0100/1000 → size 0, offset 00/01/10/11.
  - Then go to ADDR.
  - Any other nonzero wen (READ_ONLY=0) pulses `err` for one cycle and stays in IDLE.
- ADDR: `req`=1 with the latched fields.
  - `addr_ok` & `data_ok` same cycle → DONE, capture `rdata`.
  - `addr_ok` only → DATA.
- DATA: `req`=0. `data_ok` → DONE, capture `rdata` into the hold register (writes capture too; the value is don't-care).
- DONE: `sram_rdata` = hold register.
  - `longest_stall`=0 → IDLE.
  - Otherwise stay, so the stage reads data exactly once when the pipeline advances.
- stall = `sram_en` & legal & (state≠DONE). Combinational, so the request cycle itself stalls.
- Illegal wen: `stall`=0 (the exception path handles it).
- A new request is accepted in IDLE only; back-to-back accesses pass through DONE→IDLE (one idle cycle).
- `data_ok` or `addr_ok` outside their expected states is ignored.
- READ_ONLY=1: every request is size 2, wr=0, `err` never asserts.

## Timing
- Reset (`rst`=0, async): state IDLE.
  - req=0, wr=0, size=0, addr=0, wdata=0, err=0, sram_rdata=0, hold register=0.
  - stall is combinational from `sram_en`.
- Reset mid-transaction abandons the request. A later `data_ok` from the old request lands in IDLE and is ignored.
- Minimum latency with `addr_ok`=`data_ok`=1 on the first req cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: ADDR, req=1, stall=1.
  - cycle 2: DONE, stall=0, data valid.
- `req` is held high and fields stable every cycle until `addr_ok`. The slave may take any number of cycles.
- `rdata` is sampled only on the `data_ok` cycle.
- `err` asserts the same cycle as the offending `sram_en` and is registered, visible next cycle; it lasts exactly 1 cycle.

## Test plan
- Read, zero-wait slave: en=1, addr=0xBFC00000, wen=0, addr_ok=data_ok=1 on first req.
  - req high 1 cycle, size=2, wr=0.
  - DONE on cycle 2 with sram_rdata=rdata(0x3C1D0000), stall 1,1,0.
- Byte write with waits: wen=0100, addr=0x80001003, wdata=0x00AB0000; addr_ok after 3 req cycles, data_ok 2 cycles later.
  - addr=0x80001002, size=0, wr=1.
  - req high exactly 3 cycles, stall low only in DONE.
- Hold under external stall: read completes while longest_stall=1 for 4 more cycles.
  - stays DONE, sram_rdata stable, stall=0.
  - IDLE the cycle after longest_stall falls.
- Illegal enable: wen=0101.
  - err=1 for one cycle, req never asserts, stall=0, state IDLE.
- Reset mid-DATA: assert rst=0 while in DATA, release, then pulse data_ok.
  - req=0, outputs zero, no capture.
  - next en=1 starts a clean request.
- READ_ONLY=1 with wen=1111.
  - wr=0, size=2, wdata=0, err=0.

Source files
------------

// File: rtl/sram_sraml_bridge.sv
// Bridges a single-cycle SRAM-style pipeline access onto a one-outstanding
// SRAM-like req/addr_ok/data_ok handshake, holding read data until the core unstalls.
module sram_sraml_bridge #(
   parameter int unsigned ADDR_W    = 32,
   parameter bit          READ_ONLY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sram_en,
   input  logic [ADDR_W-1:0] sram_addr,
   input  logic [3:0]        sram_wen,
   input  logic [31:0]       sram_wdata,
   output logic [31:0]       sram_rdata,
   output logic              stall,
   input  logic              longest_stall,
   output logic              err,
   output logic              req,
   output logic              wr,
   output logic [1:0]        size,
   output logic [ADDR_W-1:0] addr,
   output logic [31:0]       wdata,
   input  logic              addr_ok,
   input  logic              data_ok,
   input  logic [31:0]       rdata
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                req_q;
   logic                wr_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   hold_q;
   logic                err_q, err_d;

   logic                wen_legal;
   logic [1:0]          enc_size;
   logic [1:0]          enc_off;
   logic                enc_wr;
   logic                start;
   logic                capture;

   // Byte-enable pattern to transfer size and low address bits
   always_comb begin
      wen_legal = 1'b1;
      enc_size  = 2'd2;
      enc_off   = 2'd0;
      enc_wr    = 1'b1;
      if (READ_ONLY) begin
         enc_wr = 1'b0;
      end else begin
         unique case (sram_wen)
            4'b0000: enc_wr = 1'b0;
            4'b1111: enc_size = 2'd2;
            4'b0011: enc_size = 2'd1;
            4'b1100: begin enc_size = 2'd1; enc_off = 2'd2; end
            4'b0001: enc_size = 2'd0;
            4'b0010: begin enc_size = 2'd0; enc_off = 2'd1; end
            4'b0100: begin enc_size = 2'd0; enc_off = 2'd2; end
            4'b1000: begin enc_size = 2'd0; enc_off = 2'd3; end
            default: begin
               wen_legal = 1'b0;
               enc_wr    = 1'b0;
            end
         endcase
      end
   end

   // Next-state logic; only IDLE accepts a new access
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      capture = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (sram_en) begin
               if (wen_legal) begin
                  start   = 1'b1;
                  state_d = S_ADDR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (addr_ok) begin
               if (data_ok) begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (data_ok) begin
               capture = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!longest_stall) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= (state_d == S_ADDR);
         err_q   <= err_d;
         if (start) begin
            wr_q    <= enc_wr;
            size_q  <= enc_size;
            addr_q  <= (sram_addr & ~ADDR_W'(3)) | ADDR_W'(enc_off);
            wdata_q <= READ_ONLY ? '0 : sram_wdata;
         end
         if (capture) begin
            hold_q <= rdata;
         end
      end
   end

   // Combinational so the request cycle itself freezes the stage
   assign stall      = sram_en & wen_legal & (state_q != S_DONE);
   assign req        = req_q;
   assign wr         = wr_q;
   assign size       = size_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign err        = err_q;
   assign sram_rdata = hold_q;

endmodule

// File: tb/tb_sram_sraml_bridge.sv
// Randomized bench for sram_sraml_bridge against a byte-enable arithmetic model.
module tb_sram_sraml_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        sram_en, longest_stall, addr_ok, data_ok;
   logic [31:0] sram_addr, sram_wdata, rdata;
   logic [3:0]  sram_wen;
   logic [31:0] sram_rdata, addr, wdata;
   logic        stall, err, req, wr;
   logic [1:0]  size;

   logic        ro_en, ro_lstall, ro_aok, ro_dok;
   logic [31:0] ro_addr_in, ro_wdata_in, ro_rdata_in;
   logic [3:0]  ro_wen;
   logic [31:0] ro_sram_rdata, ro_addr, ro_wdata;
   logic        ro_stall, ro_err, ro_req, ro_wr;
   logic [1:0]  ro_size;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sram_sraml_bridge #(.ADDR_W(32), .READ_ONLY(1'b0)) dut (
      .clk(clk), .rst(rst), .sram_en(sram_en), .sram_addr(sram_addr),
      .sram_wen(sram_wen), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
      .stall(stall), .longest_stall(longest_stall), .err(err), .req(req),
      .wr(wr), .size(size), .addr(addr), .wdata(wdata), .addr_ok(addr_ok),
      .data_ok(data_ok), .rdata(rdata)
   );

   sram_sraml_bridge #(.ADDR_W(32), .READ_ONLY(1'b1)) dut_ro (
      .clk(clk), .rst(rst), .sram_en(ro_en), .sram_addr(ro_addr_in),
      .sram_wen(ro_wen), .sram_wdata(ro_wdata_in), .sram_rdata(ro_sram_rdata),
      .stall(ro_stall), .longest_stall(ro_lstall), .err(ro_err), .req(ro_req),
      .wr(ro_wr), .size(ro_size), .addr(ro_addr), .wdata(ro_wdata), .addr_ok(ro_aok),
      .data_ok(ro_dok), .rdata(ro_rdata_in)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Legal patterns are 0000 or a contiguous run of 1/2/4 lanes aligned to its own size
   function automatic void model(input logic [3:0] w, output bit legal, output int sz, output int off);
      legal = 1'b0;
      sz    = 2;
      off   = 0;
      if (w == 4'd0) begin
         legal = 1'b1;
         return;
      end
      for (int k = 0; k < 3; k++) begin
         int n;
         n = 1 << k;
         for (int o = 0; o < 4; o += n) begin
            if (int'(w) == (((1 << n) - 1) << o)) begin
               legal = 1'b1;
               sz    = k;
               off   = o;
            end
         end
      end
   endfunction

   task automatic txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                      input logic [31:0] rd, input int wa, input int wd, input int hold);
      bit          legal;
      int          sz, off;
      logic [31:0] exp_addr;
      model(w, legal, sz, off);
      exp_addr = {a[31:2], 2'(off)};
      @(negedge clk);
      sram_en = 1'b1; sram_addr = a; sram_wen = w; sram_wdata = d; longest_stall = 1'b1;
      #1 chk("stall_on_request", 64'(stall), 64'(legal));
      if (!legal) begin
         @(negedge clk);
         chk("err_pulse", 64'(err), 64'd1);
         chk("err_no_req", 64'(req), 64'd0);
         sram_en = 1'b0; sram_wen = 4'd0;
         @(negedge clk);
         chk("err_one_cycle", 64'(err), 64'd0);
         chk("err_still_no_req", 64'(req), 64'd0);
         longest_stall = 1'b0;
         return;
      end
      for (int i = 0; i <= wa; i++) begin
         @(negedge clk);
         chk("req_high", 64'(req), 64'd1);
         chk("req_addr", 64'(addr), 64'(exp_addr));
         chk("req_size", 64'(size), 64'(sz));
         chk("req_wr", 64'(wr), 64'(w != 4'd0));
         if (w != 4'd0) chk("req_wdata", 64'(wdata), 64'(d));
         chk("stall_addr", 64'(stall), 64'd1);
         chk("no_err", 64'(err), 64'd0);
         addr_ok = (i == wa);
         data_ok = (i == wa) && (wd == 0);
         rdata   = data_ok ? rd : ~rd;
      end
      for (int j = 1; j <= wd; j++) begin
         @(negedge clk);
         addr_ok = 1'b0;
         chk("req_low_data", 64'(req), 64'd0);
         chk("stall_data", 64'(stall), 64'd1);
         data_ok = (j == wd);
         rdata   = data_ok ? rd : ~rd;
      end
      @(negedge clk);
      addr_ok = 1'b0; data_ok = 1'b0; rdata = $urandom;
      chk("done_req_low", 64'(req), 64'd0);
      chk("done_stall_low", 64'(stall), 64'd0);
      if (w == 4'd0) chk("done_rdata", 64'(sram_rdata), 64'(rd));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk("hold_stall_low", 64'(stall), 64'd0);
         if (w == 4'd0) chk("hold_rdata", 64'(sram_rdata), 64'(rd));
      end
      longest_stall = 1'b0;
      @(negedge clk);
      chk("back_to_idle", 64'(stall), 64'd1);
      chk("idle_req_low", 64'(req), 64'd0);
      sram_en = 1'b0;
   endtask

   initial begin
      logic [31:0] keep;
      rst = 1'b0;
      sram_en = 0; sram_addr = 0; sram_wen = 0; sram_wdata = 0; longest_stall = 0;
      addr_ok = 0; data_ok = 0; rdata = 0;
      ro_en = 0; ro_addr_in = 0; ro_wen = 0; ro_wdata_in = 0; ro_lstall = 0;
      ro_aok = 0; ro_dok = 0; ro_rdata_in = 0;
      repeat (2) @(negedge clk);
      chk("rst_req", 64'(req), 64'd0);
      chk("rst_wr", 64'(wr), 64'd0);
      chk("rst_size", 64'(size), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_rdata", 64'(sram_rdata), 64'd0);
      sram_en = 1'b1;
      #1 chk("rst_stall_comb", 64'(stall), 64'd1);
      sram_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      txn(32'hBFC0_0000, 4'b0000, 32'h0, 32'h3C1D_0000, 0, 0, 0);
      txn(32'h8000_1003, 4'b0100, 32'h00AB_0000, 32'h1111_2222, 2, 2, 0);
      txn(32'h9000_0040, 4'b0000, 32'h0, 32'h5A5A_A5A5, 1, 1, 4);
      txn(32'h8000_0000, 4'b0101, 32'h0, 32'h0, 0, 0, 0);
      txn(32'h8000_0102, 4'b1100, 32'hBEEF_0000, 32'h0, 0, 1, 0);
      txn(32'h8000_0203, 4'b1111, 32'hCAFE_BABE, 32'h0, 3, 0, 1);

      for (int t = 0; t < 40; t++) begin
         txn($urandom, 4'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
         if (t % 5 == 0) begin
            keep = sram_rdata;
            @(negedge clk);
            addr_ok = 1'b1; data_ok = 1'b1; rdata = $urandom;
            @(negedge clk);
            addr_ok = 1'b0; data_ok = 1'b0;
            chk("stray_ok_no_req", 64'(req), 64'd0);
            chk("stray_ok_no_capture", 64'(sram_rdata), 64'(keep));
         end
      end

      // Abandon a read in DATA via reset; the stale data_ok must not land
      @(negedge clk);
      sram_en = 1'b1; sram_addr = 32'h8000_0010; sram_wen = 4'd0; longest_stall = 1'b1;
      @(negedge clk);
      addr_ok = 1'b1; data_ok = 1'b0;
      @(negedge clk);
      addr_ok = 1'b0;
      chk("mid_data_req_low", 64'(req), 64'd0);
      rst = 1'b0;
      #1;
      chk("rst_mid_req", 64'(req), 64'd0);
      chk("rst_mid_addr", 64'(addr), 64'd0);
      chk("rst_mid_size", 64'(size), 64'd0);
      chk("rst_mid_rdata", 64'(sram_rdata), 64'd0);
      sram_en = 1'b0; longest_stall = 1'b0;
      @(negedge clk);
      rst = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
      @(negedge clk);
      data_ok = 1'b0;
      chk("stale_dok_ignored", 64'(sram_rdata), 64'd0);
      chk("stale_dok_no_req", 64'(req), 64'd0);
      txn(32'h8000_0020, 4'b0000, 32'h0, 32'h7777_8888, 0, 0, 0);

      // Read-only instance ignores write enables
      @(negedge clk);
      ro_en = 1'b1; ro_addr_in = 32'h0000_1003; ro_wen = 4'hF; ro_wdata_in = 32'hDEAD_BEEF; ro_lstall = 1'b1;
      #1 chk("ro_stall", 64'(ro_stall), 64'd1);
      @(negedge clk);
      chk("ro_req", 64'(ro_req), 64'd1);
      chk("ro_wr", 64'(ro_wr), 64'd0);
      chk("ro_size", 64'(ro_size), 64'd2);
      chk("ro_wdata", 64'(ro_wdata), 64'd0);
      chk("ro_addr", 64'(ro_addr), 64'h1000);
      chk("ro_err", 64'(ro_err), 64'd0);
      ro_aok = 1'b1; ro_dok = 1'b1; ro_rdata_in = 32'hCAFE_F00D;
      @(negedge clk);
      ro_aok = 1'b0; ro_dok = 1'b0;
      chk("ro_rdata", 64'(ro_sram_rdata), 64'hCAFE_F00D);
      chk("ro_done_stall", 64'(ro_stall), 64'd0);
      chk("ro_err_done", 64'(ro_err), 64'd0);
      ro_lstall = 1'b0;
      @(negedge clk);
      ro_en = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
